uart_rx_engine: RTL and testbench

// - Parametrised UART receiver: oversampled start detect, majority-vote bit sampling, runtime frame format.
// - Frame format: 5-9 data bits, none/even/odd parity, 1-2 stop bits.
// - Emits each received word with error flags over a valid/ready handshake. Overrun and break are detected.
// - Sits between the baud-tick generator and the peripheral bus register file.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_rx_sampler.sv | 78 +++++++
 rtl/uart_rx_engine.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_pkg                                                  |
// | Purpose  : Shared types and constants for the UART receive path:     |
// |            parity mode encoding, receiver FSM states, and the helper |
// |            that turns a raw data-bit setting into an effective one.  |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE  = 2'b00,
      PAR_EVEN  = 2'b01,
      PAR_ODD   = 2'b10,
      PAR_NONE2 = 2'b11
   } parity_e;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_e;

   localparam int MIN_DATA_BITS = 5;

   // Out-of-range data-bit settings fall back to the common 8-bit format.
   function automatic logic [3:0] eff_data_bits(input logic [3:0] cfg, input int max_bits);
      if (int'(cfg) >= MIN_DATA_BITS && int'(cfg) <= max_bits) begin
         return cfg;
      end
      return 4'd8;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx_sampler                                           |
// | Purpose  : Synchronises the serial line, tracks the tick phase inside |
// |            the current bit period and forms a 3-sample majority vote.|
// | Ports    : clk, reset (sync, active-low), baud_tick, rx_in (async)   |
// |            start  - restart phase at the start-edge tick             |
// |            active - frame in progress, phase runs and votes issue    |
// |            line   - synchronised line level                          |
// |            fall_edge  - 1->0 of the synchronised line on a tick      |
// |            bit_strobe - 1 cycle at the vote point of each bit        |
// |            bit_value  - majority vote, valid with bit_strobe         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic baud_tick,
   input  logic rx_in,
   input  logic start,
   input  logic active,
   output logic line,
   output logic fall_edge,
   output logic bit_strobe,
   output logic bit_value
);

   localparam int            PW      = $clog2(OVERSAMPLE);
   localparam logic [PW-1:0] PH_S0   = PW'(OVERSAMPLE / 2 - 1);
   localparam logic [PW-1:0] PH_S1   = PW'(OVERSAMPLE / 2);
   localparam logic [PW-1:0] PH_S2   = PW'(OVERSAMPLE / 2 + 1);
   localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   line_prev;
   logic [PW-1:0]          phase;
   logic                   samp0;
   logic                   samp1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q    <= '1;
         line_prev <= 1'b1;
         phase     <= '0;
         samp0     <= 1'b0;
         samp1     <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
         if (baud_tick) begin
            line_prev <= line;
            // The start-edge tick is offset 0 of the start bit, so the
            // next tick is offset 1; the phase then wraps every bit period.
            if (start) begin
               phase <= PW'(1);
            end else if (active) begin
               phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
            end else begin
               phase <= '0;
            end
            if (active && phase == PH_S0) samp0 <= line;
            if (active && phase == PH_S1) samp1 <= line;
         end
      end
   end

   assign line       = sync_q[SYNC_STAGES-1];
   assign fall_edge  = baud_tick & line_prev & ~line;
   assign bit_strobe = baud_tick & active & (phase == PH_S2);
   // Third sample is the live line at the vote tick.
   assign bit_value  = (samp0 & samp1) | (samp0 & line) | (samp1 & line);

endmodule
`default_nettype wire

// File: rtl/uart_rx_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx_engine                                            |
// | Purpose  : UART receiver with runtime frame format (5-9 data bits,   |
// |            none/even/odd parity, 1-2 stop bits), error flags, break |
// |            and overrun detection, valid/ready output handshake.      |
// | Ports    : clk, reset (sync, active-low), baud_tick, rx_in           |
// |            cfg_data_bits, cfg_parity, cfg_stop2 - latched per frame  |
// |            rx_data, rx_valid, rx_ready - word handshake              |
// |            parity_err, frame_err, break_det - qualified by rx_valid  |
// |            overrun - 1-cycle pulse, busy - FSM not idle              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module uart_rx_engine
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE    = 16,
   parameter int MAX_DATA_BITS = 9,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     baud_tick,
   input  logic                     rx_in,
   input  logic [3:0]               cfg_data_bits,
   input  logic [1:0]               cfg_parity,
   input  logic                     cfg_stop2,
   output logic [MAX_DATA_BITS-1:0] rx_data,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic                     parity_err,
   output logic                     frame_err,
   output logic                     break_det,
   output logic                     overrun,
   output logic                     busy
);

   state_e                   state;
   state_e                   state_nxt;
   logic                     line;
   logic                     fall_edge;
   logic                     bit_strobe;
   logic                     bit_value;
   logic                     start;
   logic                     active;
   logic                     complete;
   logic [3:0]               nbits;
   parity_e                  par_mode;
   logic                     stop2_l;
   logic [3:0]               bit_cnt;
   logic                     stop_cnt;
   logic [MAX_DATA_BITS-1:0] shift;
   logic                     par_acc;
   logic                     perr_acc;
   logic                     ferr_acc;
   logic                     any_one;

   assign start  = (state == S_IDLE) && fall_edge;
   assign active = (state == S_START) || (state == S_DATA) ||
                   (state == S_PARITY) || (state == S_STOP);
   assign busy   = (state != S_IDLE);

   uart_rx_sampler #(
      .OVERSAMPLE  (OVERSAMPLE),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sampler (
      .clk        (clk),
      .reset      (reset),
      .baud_tick  (baud_tick),
      .rx_in      (rx_in),
      .start      (start),
      .active     (active),
      .line       (line),
      .fall_edge  (fall_edge),
      .bit_strobe (bit_strobe),
      .bit_value  (bit_value)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      complete  = 1'b0;
      case (state)
         S_IDLE:   if (fall_edge) state_nxt = S_START;
         S_START:  if (bit_strobe) state_nxt = bit_value ? S_IDLE : S_DATA;
         S_DATA: begin
            if (bit_strobe && bit_cnt == nbits - 4'd1) begin
               state_nxt = (par_mode == PAR_EVEN || par_mode == PAR_ODD) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: if (bit_strobe) state_nxt = S_STOP;
         S_STOP: begin
            // Finish at the vote of the last stop bit; a low line here
            // means a break, which must not retrigger a new frame.
            if (bit_strobe && stop_cnt == stop2_l) begin
               complete  = 1'b1;
               state_nxt = line ? S_IDLE : S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: if (baud_tick && line) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         nbits      <= '0;
         par_mode   <= PAR_NONE;
         stop2_l    <= 1'b0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         shift      <= '0;
         par_acc    <= 1'b0;
         perr_acc   <= 1'b0;
         ferr_acc   <= 1'b0;
         any_one    <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;

         if (start) begin
            nbits    <= eff_data_bits(cfg_data_bits, MAX_DATA_BITS);
            par_mode <= parity_e'(cfg_parity);
            stop2_l  <= cfg_stop2;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            par_acc  <= 1'b0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            any_one  <= 1'b0;
         end

         if (bit_strobe) begin
            case (state)
               S_DATA: begin
                  shift[bit_cnt] <= bit_value;
                  par_acc        <= par_acc ^ bit_value;
                  any_one        <= any_one | bit_value;
                  bit_cnt        <= bit_cnt + 4'd1;
               end
               S_PARITY: begin
                  perr_acc <= (par_acc ^ bit_value) != (par_mode == PAR_ODD);
                  any_one  <= any_one | bit_value;
               end
               S_STOP: begin
                  ferr_acc <= ferr_acc | ~bit_value;
                  any_one  <= any_one | bit_value;
                  stop_cnt <= 1'b1;
               end
               default: ;
            endcase
         end

         // Final stop-bit sample is folded in directly since its
         // accumulator update lands on the same edge as the load.
         if (complete) begin
            if (!rx_valid || rx_ready) begin
               rx_valid   <= 1'b1;
               rx_data    <= shift;
               parity_err <= perr_acc;
               frame_err  <= ferr_acc | ~bit_value;
               break_det  <= ~(any_one | bit_value);
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_rx_engine                                         |
// | Purpose  : Self-checking bench for uart_rx_engine: table of frames,  |
// |            randomized frames against a frame-level reference model,  |
// |            and directed sequences for false start, overrun, break    |
// |            and mid-frame reset.                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_uart_rx_engine;

   localparam int OS       = 16;
   localparam int MAXB     = 9;
   localparam int TICK_DIV = 4;
   localparam int BIT_CLKS = OS * TICK_DIV;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           baud_tick = 1'b0;
   logic           rx_in = 1'b1;
   logic [3:0]     cfg_data_bits = 4'd8;
   logic [1:0]     cfg_parity = 2'd0;
   logic           cfg_stop2 = 1'b0;
   logic           rx_ready = 1'b1;
   logic [MAXB-1:0] rx_data;
   logic           rx_valid;
   logic           parity_err;
   logic           frame_err;
   logic           break_det;
   logic           overrun;
   logic           busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [8:0] d;
      logic       p;
      logic       f;
      logic       b;
   } word_t;

   typedef struct {
      logic [3:0] cfg;
      int         n;
      logic [1:0] par;
      logic       s2;
      logic [8:0] data;
      logic       flip;
      logic       stopv;
      logic [8:0] exp_d;
      logic       exp_p;
      logic       exp_f;
      logic       exp_b;
   } vec_t;

   word_t got_q[$];
   logic  frame_q[$];
   int    ov_cnt = 0;
   int    stab_err = 0;
   logic  prev_valid = 1'b0;
   logic  prev_accept = 1'b0;
   logic [8:0] prev_data = '0;
   int    tdiv = 0;

   uart_rx_engine #(
      .OVERSAMPLE    (OS),
      .MAX_DATA_BITS (MAXB),
      .SYNC_STAGES   (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .baud_tick     (baud_tick),
      .rx_in         (rx_in),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop2     (cfg_stop2),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .parity_err    (parity_err),
      .frame_err     (frame_err),
      .break_det     (break_det),
      .overrun       (overrun),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      tdiv      = (tdiv + 1) % TICK_DIV;
      baud_tick = (tdiv == 0);
   end

   // Monitor on the falling edge: records accepted words, overrun pulses
   // and any change of a held, unaccepted word.
   always @(negedge clk) begin
      if (!reset) begin
         prev_valid  = 1'b0;
         prev_accept = 1'b0;
      end else begin
         word_t w;
         if (overrun) ov_cnt++;
         if (prev_valid && !prev_accept && rx_valid && rx_data !== prev_data) stab_err++;
         if (rx_valid && rx_ready) begin
            w.d = rx_data; w.p = parity_err; w.f = frame_err; w.b = break_det;
            got_q.push_back(w);
         end
         prev_valid  = rx_valid;
         prev_accept = rx_valid && rx_ready;
         prev_data   = rx_data;
      end
   end

   initial begin
      #50_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic v);
      rx_in = v;
      clks(BIT_CLKS);
   endtask

   // Line bits following the start bit: data LSB first, optional parity, stops.
   task automatic make_frame(input logic [8:0] data, input int n, input logic [1:0] par,
                             input logic s2, input logic flip, input logic stopv);
      logic p;
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(data[i]);
      if (par == 2'd1 || par == 2'd2) begin
         p = 1'b0;
         for (int i = 0; i < n; i++) p = p ^ data[i];
         if (par == 2'd2) p = ~p;
         if (flip) p = ~p;
         frame_q.push_back(p);
      end
      frame_q.push_back(stopv);
      if (s2) frame_q.push_back(stopv);
   endtask

   task automatic send_frame_q();
      send_bit(1'b0);
      for (int i = 0; i < frame_q.size(); i++) send_bit(frame_q[i]);
      send_bit(1'b1);
   endtask

   // Reference: what a receiver should report for the bits in frame_q.
   function automatic word_t model(input int n, input logic [1:0] par, input logic s2);
      word_t w;
      int    ones;
      int    k;
      logic  allz;
      w.d  = '0;
      ones = 0;
      allz = 1'b1;
      for (int i = 0; i < frame_q.size(); i++) if (frame_q[i]) allz = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (frame_q[i]) begin
            w.d  = w.d + 9'(1 << i);
            ones = ones + 1;
         end
      end
      k   = n;
      w.p = 1'b0;
      if (par == 2'd1 || par == 2'd2) begin
         if (frame_q[n]) ones = ones + 1;
         w.p = (par == 2'd1) ? ((ones % 2) != 0) : ((ones % 2) != 1);
         k   = n + 1;
      end
      w.f = (frame_q[k] == 1'b0);
      if (s2 && frame_q[k+1] == 1'b0) w.f = 1'b1;
      w.b = allz;
      return w;
   endfunction

   task automatic run_frame(input logic [3:0] cfg, input int n, input logic [1:0] par,
                            input logic s2, input logic [8:0] data, input logic flip,
                            input logic stopv);
      cfg_data_bits = cfg;
      cfg_parity    = par;
      cfg_stop2     = s2;
      got_q.delete();
      make_frame(data, n, par, s2, flip, stopv);
      send_frame_q();
   endtask

   vec_t  vecs[10];
   word_t exp_w;

   initial begin
      vecs[0] = '{4'd8,  8, 2'd0, 1'b0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{4'd7,  7, 2'd1, 1'b1, 9'h055, 1'b1, 1'b1, 9'h055, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{4'd9,  9, 2'd2, 1'b0, 9'h1FF, 1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{4'd5,  5, 2'd0, 1'b0, 9'h01F, 1'b0, 1'b1, 9'h01F, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{4'd8,  8, 2'd0, 1'b0, 9'h03C, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{4'd6,  6, 2'd2, 1'b0, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{4'd12, 8, 2'd0, 1'b0, 9'h0C3, 1'b0, 1'b1, 9'h0C3, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{4'd8,  8, 2'd3, 1'b1, 9'h05A, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{4'd8,  8, 2'd1, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b1};
      vecs[9] = '{4'd5,  5, 2'd1, 1'b1, 9'h1FE, 1'b0, 1'b1, 9'h01E, 1'b0, 1'b0, 1'b0};

      // Reset state
      reset = 1'b0;
      clks(5);
      check("reset_valid", 32'(rx_valid), 32'd0);
      check("reset_data", 32'(rx_data), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_flags", 32'({parity_err, frame_err, break_det, overrun}), 32'd0);
      reset = 1'b1;
      clks(2 * BIT_CLKS);

      // Table-driven frames
      rx_ready = 1'b1;
      for (int v = 0; v < 10; v++) begin
         run_frame(vecs[v].cfg, vecs[v].n, vecs[v].par, vecs[v].s2,
                   vecs[v].data, vecs[v].flip, vecs[v].stopv);
         check($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'd1);
         if (got_q.size() > 0) begin
            check($sformatf("vec%0d_data", v), 32'(got_q[0].d), 32'(vecs[v].exp_d));
            check($sformatf("vec%0d_flags", v), 32'({got_q[0].p, got_q[0].f, got_q[0].b}),
                  32'({vecs[v].exp_p, vecs[v].exp_f, vecs[v].exp_b}));
         end
      end

      // Randomized frames against the reference model
      for (int r = 0; r < 16; r++) begin
         int         n;
         logic [1:0] par;
         logic       s2, flip, stopv;
         logic [8:0] data;
         n     = $urandom_range(5, 9);
         par   = 2'($urandom_range(0, 3));
         s2    = 1'($urandom_range(0, 1));
         flip  = ($urandom_range(0, 3) == 0);
         stopv = ($urandom_range(0, 5) != 0);
         data  = 9'($urandom);
         if ($urandom_range(0, 4) == 0) data = '0;
         run_frame(4'(n), n, par, s2, data, flip, stopv);
         exp_w = model(n, par, s2);
         check($sformatf("rnd%0d_count", r), 32'(got_q.size()), 32'd1);
         if (got_q.size() > 0) begin
            check($sformatf("rnd%0d_data", r), 32'(got_q[0].d), 32'(exp_w.d));
            check($sformatf("rnd%0d_flags", r), 32'({got_q[0].p, got_q[0].f, got_q[0].b}),
                  32'({exp_w.p, exp_w.f, exp_w.b}));
         end
      end

      // False start: short low pulse, no word, busy clears within a bit period
      cfg_data_bits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
      got_q.delete();
      rx_in = 1'b0;
      clks(3 * TICK_DIV);
      check("false_start_busy", 32'(busy), 32'd1);
      rx_in = 1'b1;
      for (int i = 0; i < BIT_CLKS; i++) begin
         if (!busy) break;
         clks(1);
      end
      check("false_start_idle", 32'(busy), 32'd0);
      clks(BIT_CLKS);
      check("false_start_noword", 32'(got_q.size() + int'(rx_valid)), 32'd0);

      // Overrun: two frames with consumer stalled
      rx_ready = 1'b0;
      ov_cnt   = 0;
      run_frame(4'd8, 8, 2'd0, 1'b0, 9'h03C, 1'b0, 1'b1);
      run_frame(4'd8, 8, 2'd0, 1'b0, 9'h03C, 1'b0, 1'b1);
      check("ovr_valid", 32'(rx_valid), 32'd1);
      check("ovr_data", 32'(rx_data), 32'h03C);
      check("ovr_pulses", 32'(ov_cnt), 32'd1);
      got_q.delete();
      rx_ready = 1'b1;
      clks(BIT_CLKS);
      check("ovr_drain_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) check("ovr_drain_data", 32'(got_q[0].d), 32'h03C);
      check("ovr_drain_valid", 32'(rx_valid), 32'd0);

      // Break: line low for two frame times
      got_q.delete();
      rx_in = 1'b0;
      clks(20 * BIT_CLKS);
      check("brk_count_low", 32'(got_q.size()), 32'd1);
      check("brk_wait_busy", 32'(busy), 32'd1);
      rx_in = 1'b1;
      clks(2 * BIT_CLKS);
      check("brk_count_high", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) begin
         check("brk_data", 32'(got_q[0].d), 32'd0);
         check("brk_flags", 32'({got_q[0].p, got_q[0].f, got_q[0].b}), 32'b011);
      end
      check("brk_idle", 32'(busy), 32'd0);

      // Reset in the middle of the data bits while a word is held
      rx_ready = 1'b0;
      run_frame(4'd8, 8, 2'd0, 1'b0, 9'h05A, 1'b0, 1'b1);
      check("rst_held_valid", 32'(rx_valid), 32'd1);
      rx_in = 1'b0;
      clks(BIT_CLKS);
      rx_in = 1'b1;
      clks(BIT_CLKS / 2);
      reset = 1'b0;
      clks(1);
      reset = 1'b1;
      check("rst_valid", 32'(rx_valid), 32'd0);
      check("rst_data", 32'(rx_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      clks(2 * BIT_CLKS);
      rx_ready = 1'b1;
      run_frame(4'd8, 8, 2'd0, 1'b0, 9'h081, 1'b0, 1'b1);
      check("rst_next_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) begin
         check("rst_next_data", 32'(got_q[0].d), 32'h081);
         check("rst_next_flags", 32'({got_q[0].p, got_q[0].f, got_q[0].b}), 32'd0);
      end

      check("hold_stable", 32'(stab_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
